// File: rtl/exec_ctrl_pkg.sv
// Shared definitions for the issue/execute controller: opcodes, FSM states, field widths.
// Optional CMP opcode is enabled in exec_alu by EXEC_CTRL_CMP_EN.
package exec_ctrl_pkg;

   localparam int OPC_W = 4;

   localparam logic [OPC_W-1:0] OP_NOP = 4'h0;
   localparam logic [OPC_W-1:0] OP_ADD = 4'h1;
   localparam logic [OPC_W-1:0] OP_SUB = 4'h2;
   localparam logic [OPC_W-1:0] OP_AND = 4'h3;
   localparam logic [OPC_W-1:0] OP_OR  = 4'h4;
   localparam logic [OPC_W-1:0] OP_XOR = 4'h5;
   localparam logic [OPC_W-1:0] OP_SHL = 4'h6;
   localparam logic [OPC_W-1:0] OP_SHR = 4'h7;
   localparam logic [OPC_W-1:0] OP_LDI = 4'h8;
   localparam logic [OPC_W-1:0] OP_MOV = 4'h9;
   localparam logic [OPC_W-1:0] OP_CMP = 4'hA;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      EXEC = 2'd2
   } state_t;

endpackage

// File: rtl/exec_alu.sv
// Combinational ALU for exec_ctrl: result, carry/borrow and per-opcode control qualifiers.
// EXEC_CTRL_CMP_EN adds opcode 0xA (CMP); otherwise 0xA decodes as illegal.
module exec_alu
   import exec_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int IMM_WIDTH  = 8
) (
   input  logic [OPC_W-1:0]      opcode,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   input  logic [IMM_WIDTH-1:0]  imm,
   output logic [DATA_WIDTH-1:0] result,
   output logic                  carry,
   output logic                  writes_rd,
   output logic                  updates_flags,
   output logic                  illegal
);

   localparam int SH_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   logic [DATA_WIDTH:0]   sum;
   logic [DATA_WIDTH-1:0] diff;
   logic [DATA_WIDTH-1:0] imm_res;
   logic [SH_W-1:0]       shamt;

   assign sum   = {1'b0, a} + {1'b0, b};
   assign diff  = a - b;
   assign shamt = b[SH_W-1:0];

   // Immediate is zero-extended or truncated to the datapath width.
   always_comb begin
      imm_res = '0;
      for (int i = 0; i < DATA_WIDTH && i < IMM_WIDTH; i++) imm_res[i] = imm[i];
   end

   always_comb begin
      result        = '0;
      carry         = 1'b0;
      writes_rd     = 1'b1;
      updates_flags = 1'b0;
      illegal       = 1'b0;
      case (opcode)
         OP_NOP: writes_rd = 1'b0;
         OP_ADD: begin
            result        = sum[DATA_WIDTH-1:0];
            carry         = sum[DATA_WIDTH];
            updates_flags = 1'b1;
         end
         OP_SUB: begin
            result        = diff;
            carry         = (a < b);
            updates_flags = 1'b1;
         end
         OP_AND: begin result = a & b;        updates_flags = 1'b1; end
         OP_OR:  begin result = a | b;        updates_flags = 1'b1; end
         OP_XOR: begin result = a ^ b;        updates_flags = 1'b1; end
         OP_SHL: begin result = a << shamt;   updates_flags = 1'b1; end
         OP_SHR: begin result = a >> shamt;   updates_flags = 1'b1; end
         OP_LDI: result = imm_res;
         OP_MOV: result = a;
`ifdef EXEC_CTRL_CMP_EN
         OP_CMP: begin
            result        = diff;
            carry         = (a < b);
            writes_rd     = 1'b0;
            updates_flags = 1'b1;
         end
`endif
         default: begin
            writes_rd = 1'b0;
            illegal   = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/exec_ctrl.sv
// Two-phase issue/execute controller around the GPR file: READ drives read addresses,
// EXEC consumes registered operands and writes back. Optional CMP via EXEC_CTRL_CMP_EN.
module exec_ctrl
   import exec_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH    = 8,
   parameter int REG_FILE_SIZE = 16,
   parameter int ADDR_WIDTH    = $clog2(REG_FILE_SIZE),
   parameter int INSTR_WIDTH   = OPC_W + 3*ADDR_WIDTH
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   instr_valid,
   output logic                   instr_ready,
   input  logic [INSTR_WIDTH-1:0] instr,
   output logic [ADDR_WIDTH-1:0]  rf_addr_a,
   output logic [ADDR_WIDTH-1:0]  rf_addr_b,
   input  logic [DATA_WIDTH-1:0]  rf_operand_a,
   input  logic [DATA_WIDTH-1:0]  rf_operand_b,
   output logic                   rf_wen,
   output logic [ADDR_WIDTH-1:0]  rf_addr_write,
   output logic [DATA_WIDTH-1:0]  rf_data_in,
   output logic                   res_valid,
   output logic [DATA_WIDTH-1:0]  res_data,
   output logic                   flag_z,
   output logic                   flag_c,
   output logic                   illegal
);

   state_t                 state, state_nxt;
   logic                   load;
   logic                   exec_cyc;
   logic [INSTR_WIDTH-1:0] instr_q;
   logic [OPC_W-1:0]       opcode;
   logic [ADDR_WIDTH-1:0]  rd, rs1, rs2;

   logic [DATA_WIDTH-1:0]  alu_result;
   logic                   alu_carry;
   logic                   alu_writes;
   logic                   alu_upd;
   logic                   alu_illegal;

   assign opcode = instr_q[INSTR_WIDTH-1 -: OPC_W];
   assign rd     = instr_q[3*ADDR_WIDTH-1 -: ADDR_WIDTH];
   assign rs1    = instr_q[2*ADDR_WIDTH-1 -: ADDR_WIDTH];
   assign rs2    = instr_q[ADDR_WIDTH-1:0];

   exec_alu #(
      .DATA_WIDTH (DATA_WIDTH),
      .IMM_WIDTH  (2*ADDR_WIDTH)
   ) u_alu (
      .opcode        (opcode),
      .a             (rf_operand_a),
      .b             (rf_operand_b),
      .imm           ({rs1, rs2}),
      .result        (alu_result),
      .carry         (alu_carry),
      .writes_rd     (alu_writes),
      .updates_flags (alu_upd),
      .illegal       (alu_illegal)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // EXEC also accepts so back-to-back issue sustains one instruction per two cycles.
   always_comb begin
      state_nxt   = state;
      instr_ready = 1'b0;
      load        = 1'b0;
      case (state)
         IDLE: begin
            instr_ready = 1'b1;
            if (instr_valid) begin
               load      = 1'b1;
               state_nxt = READ;
            end
         end
         READ: state_nxt = EXEC;
         EXEC: begin
            instr_ready = 1'b1;
            load        = instr_valid;
            state_nxt   = instr_valid ? READ : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Read addresses come straight from the latched word; reset clears it, so they idle at 0.
   assign rf_addr_a = rs1;
   assign rf_addr_b = rs2;

   // Reset in EXEC suppresses the write so an aborted instruction never reaches the GPRs.
   assign exec_cyc      = (state == EXEC) && !reset;
   assign rf_wen        = exec_cyc && alu_writes;
   assign rf_addr_write = exec_cyc ? rd : '0;
   assign rf_data_in    = exec_cyc ? alu_result : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         instr_q   <= '0;
         res_valid <= 1'b0;
         res_data  <= '0;
         flag_z    <= 1'b0;
         flag_c    <= 1'b0;
         illegal   <= 1'b0;
      end else begin
         if (load) instr_q <= instr;
         res_valid <= (state == EXEC);
         illegal   <= (state == EXEC) && alu_illegal;
         if (state == EXEC) begin
            res_data <= alu_result;
            if (alu_upd) begin
               flag_z <= (alu_result == '0);
               flag_c <= alu_carry;
            end
         end
      end
   end

endmodule

// File: tb/tb_exec_ctrl.sv
// Self-checking bench for exec_ctrl: behavioural register file, architectural reference
// model and latency-stamped scoreboard; directed test-plan scenarios plus random streams.
module tb_exec_ctrl;

   localparam int DW  = 8;
   localparam int RFS = 16;
   localparam int AW  = 4;
   localparam int IW  = 16;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          instr_valid = 1'b0;
   logic [IW-1:0] instr = '0;
   logic          instr_ready;
   logic [AW-1:0] rf_addr_a, rf_addr_b, rf_addr_write;
   logic [DW-1:0] rf_operand_a, rf_operand_b, rf_data_in, res_data;
   logic          rf_wen, res_valid, flag_z, flag_c, illegal;

   always #5 clk = ~clk;

   exec_ctrl #(
      .DATA_WIDTH    (DW),
      .REG_FILE_SIZE (RFS),
      .ADDR_WIDTH    (AW),
      .INSTR_WIDTH   (IW)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .instr_valid   (instr_valid),
      .instr_ready   (instr_ready),
      .instr         (instr),
      .rf_addr_a     (rf_addr_a),
      .rf_addr_b     (rf_addr_b),
      .rf_operand_a  (rf_operand_a),
      .rf_operand_b  (rf_operand_b),
      .rf_wen        (rf_wen),
      .rf_addr_write (rf_addr_write),
      .rf_data_in    (rf_data_in),
      .res_valid     (res_valid),
      .res_data      (res_data),
      .flag_z        (flag_z),
      .flag_c        (flag_c),
      .illegal       (illegal)
   );

   // Register file: registered reads, index 0 discards writes.
   logic          rf_init = 1'b1;
   logic [DW-1:0] rf_mem [RFS];
   always @(posedge clk) begin
      if (rf_init) begin
         for (int i = 0; i < RFS; i++) rf_mem[i] <= '0;
      end else if (rf_wen && rf_addr_write != 0) begin
         rf_mem[rf_addr_write] <= rf_data_in;
      end
      rf_operand_a <= rf_mem[rf_addr_a];
      rf_operand_b <= rf_mem[rf_addr_b];
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int       t;
      bit       wr;
      bit [3:0] rd;
      bit [7:0] data;
      bit       ill;
      bit       z;
      bit       c;
   } exp_t;

   exp_t          pend[$];
   logic [15:0]   stim[$];
   int            acc_t[$];
   int            arch[RFS];
   bit            z_m, c_m;
   int            checks = 0;
   int            errors = 0;
   logic [7:0]    last_res;
   logic          last_z, last_c, last_ill;

   // Architectural reference: apply one instruction to the model state in issue order.
   task automatic model(input logic [15:0] w, input int t);
      exp_t e;
      int   op, rd, r1, r2, a, b, s;
      bit   cc, upd;
      op = int'(w[15:12]); rd = int'(w[11:8]); r1 = int'(w[7:4]); r2 = int'(w[3:0]);
      a = arch[r1]; b = arch[r2];
      s = 0; cc = 0; upd = 0;
      e.t = t; e.rd = w[11:8]; e.wr = 1; e.ill = 0;
      case (op)
         0:  e.wr = 0;
         1:  begin s = a + b; cc = (s > 255); upd = 1; end
         2:  begin s = a - b; cc = (a < b);   upd = 1; end
         3:  begin s = a & b; upd = 1; end
         4:  begin s = a | b; upd = 1; end
         5:  begin s = a ^ b; upd = 1; end
         6:  begin s = a << (b % 8); upd = 1; end
         7:  begin s = a >> (b % 8); upd = 1; end
         8:  s = r1 * 16 + r2;
         9:  s = a;
`ifdef EXEC_CTRL_CMP_EN
         10: begin s = a - b; cc = (a < b); upd = 1; e.wr = 0; end
`endif
         default: begin e.wr = 0; e.ill = 1; end
      endcase
      s = s & 255;
      e.data = 8'(s);
      if (upd) begin z_m = (s == 0); c_m = cc; end
      e.z = z_m; e.c = c_m;
      if (e.wr && rd != 0) arch[rd] = s;
      pend.push_back(e);
   endtask

   // Drive stim[] and score every cycle: ready low only in READ (accept+1),
   // write at accept+2, result pulse at accept+3.
   task automatic run(input int gap_pct, input int max_cyc);
      int   n;
      bit   hold, busy, wslot, rslot;
      exp_t we, re;
      n = 0; hold = 0; acc_t.delete();
      we = '{default: 0}; re = '{default: 0};
      while ((stim.size() > 0 || pend.size() > 0) && n < max_cyc) begin
         @(negedge clk); n++;
         busy = 0; wslot = 0; rslot = 0;
         foreach (pend[i]) begin
            if (pend[i].t + 1 == cyc) busy = 1;
            if (pend[i].t + 2 == cyc) begin wslot = 1; we = pend[i]; end
            if (pend[i].t + 3 == cyc) begin rslot = 1; re = pend[i]; end
         end
         checks++;
         if (instr_ready !== !busy) begin
            errors++; $display("FAIL ready cyc=%0d got=%b exp=%b", cyc, instr_ready, !busy);
         end
         checks++;
         if (rf_wen !== (wslot && we.wr)) begin
            errors++; $display("FAIL rf_wen cyc=%0d got=%b exp=%b", cyc, rf_wen, wslot && we.wr);
         end
         if (wslot && we.wr) begin
            checks++;
            if (rf_addr_write !== we.rd || rf_data_in !== we.data) begin
               errors++;
               $display("FAIL writeback cyc=%0d got addr=%0d data=%h exp addr=%0d data=%h",
                        cyc, rf_addr_write, rf_data_in, we.rd, we.data);
            end
         end
         checks++;
         if (res_valid !== rslot || illegal !== (rslot && re.ill)) begin
            errors++;
            $display("FAIL res_pulse cyc=%0d got valid=%b ill=%b exp valid=%b ill=%b",
                     cyc, res_valid, illegal, rslot, rslot && re.ill);
         end
         if (rslot) begin
            checks++;
            if (res_data !== re.data || flag_z !== re.z || flag_c !== re.c) begin
               errors++;
               $display("FAIL result cyc=%0d got d=%h z=%b c=%b exp d=%h z=%b c=%b",
                        cyc, res_data, flag_z, flag_c, re.data, re.z, re.c);
            end
            last_res = res_data; last_z = flag_z; last_c = flag_c; last_ill = illegal;
            void'(pend.pop_front());
         end
         if (stim.size() > 0 && (hold || $urandom_range(0, 99) >= gap_pct)) begin
            instr_valid = 1'b1;
            instr = stim[0];
            if (instr_ready) begin
               model(stim.pop_front(), cyc);
               acc_t.push_back(cyc);
               hold = 0;
            end else begin
               hold = 1;
            end
         end else begin
            instr_valid = 1'b0;
            instr = 16'($urandom);
         end
      end
      instr_valid = 1'b0;
      if (n >= max_cyc) begin
         errors++; $display("FAIL timeout got=%0d cycles limit=%0d", n, max_cyc);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; rf_init = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (instr_ready !== 1'b1 || rf_wen !== 1'b0 || res_valid !== 1'b0 || illegal !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl got rdy=%b wen=%b vld=%b ill=%b exp 1 0 0 0",
                  instr_ready, rf_wen, res_valid, illegal);
      end
      checks++;
      if (res_data !== 8'h00 || flag_z !== 1'b0 || flag_c !== 1'b0 || rf_addr_a !== 4'h0 ||
          rf_addr_b !== 4'h0 || rf_addr_write !== 4'h0 || rf_data_in !== 8'h00) begin
         errors++;
         $display("FAIL reset_data got d=%h z=%b c=%b a=%0d b=%0d w=%0d din=%h exp all zero",
                  res_data, flag_z, flag_c, rf_addr_a, rf_addr_b, rf_addr_write, rf_data_in);
      end
      reset = 1'b0; rf_init = 1'b0;
      for (int i = 0; i < RFS; i++) arch[i] = 0;
      z_m = 0; c_m = 0; pend.delete();
   endtask

   task automatic test_arith();
      stim = '{16'h8105, 16'h8203, 16'h1312};
      run(0, 100);
      checks++;
      if (last_res !== 8'h08 || last_z !== 1'b0 || last_c !== 1'b0 || rf_mem[3] !== 8'h08) begin
         errors++;
         $display("FAIL add_basic got d=%h z=%b c=%b r3=%h exp 08 0 0 08", last_res, last_z, last_c, rf_mem[3]);
      end
      stim = '{16'h81FF, 16'h8201, 16'h1412};
      run(0, 100);
      checks++;
      if (last_res !== 8'h00 || last_z !== 1'b1 || last_c !== 1'b1 || rf_mem[4] !== 8'h00) begin
         errors++;
         $display("FAIL add_carry got d=%h z=%b c=%b r4=%h exp 00 1 1 00", last_res, last_z, last_c, rf_mem[4]);
      end
      stim = '{16'h2521};
      run(0, 100);
      checks++;
      if (last_res !== 8'h02 || last_z !== 1'b0 || last_c !== 1'b1) begin
         errors++;
         $display("FAIL sub_borrow got d=%h z=%b c=%b exp 02 0 1", last_res, last_z, last_c);
      end
   endtask

   task automatic test_back_to_back();
      stim = '{16'h860A, 16'h9760, 16'h8033, 16'h9830};
      run(0, 100);
      checks++;
      if (acc_t.size() != 4 || acc_t[1] - acc_t[0] != 2 || acc_t[3] - acc_t[2] != 2) begin
         errors++;
         $display("FAIL b2b_rate got accepts=%0d gap=%0d exp 4 accepts gap 2",
                  acc_t.size(), (acc_t.size() > 1) ? acc_t[1] - acc_t[0] : -1);
      end
      checks++;
      if (rf_mem[7] !== 8'h0A) begin
         errors++; $display("FAIL b2b_mov got r7=%h exp 0a", rf_mem[7]);
      end
   endtask

   task automatic test_r0_illegal();
      stim = '{16'h8055, 16'h9100};
      run(0, 100);
      checks++;
      if (last_res !== 8'h00 || rf_mem[1] !== 8'h00) begin
         errors++; $display("FAIL r0_discard got d=%h r1=%h exp 00 00", last_res, rf_mem[1]);
      end
      stim = '{16'hF123};
      run(0, 100);
      checks++;
      if (last_ill !== 1'b1 || last_res !== 8'h00 || last_z !== 1'b0 || last_c !== 1'b1) begin
         errors++;
         $display("FAIL illegal_op got ill=%b d=%h z=%b c=%b exp 1 00 0 1", last_ill, last_res, last_z, last_c);
      end
   endtask

   task automatic test_cmp();
      stim = '{16'h8103, 16'h8203, 16'hA012};
      run(0, 100);
      checks++;
`ifdef EXEC_CTRL_CMP_EN
      if (last_ill !== 1'b0 || last_z !== 1'b1 || last_c !== 1'b0 || last_res !== 8'h00) begin
         errors++;
         $display("FAIL cmp_op got ill=%b z=%b c=%b d=%h exp 0 1 0 00", last_ill, last_z, last_c, last_res);
      end
`else
      if (last_ill !== 1'b1 || last_res !== 8'h00) begin
         errors++; $display("FAIL cmp_illegal got ill=%b d=%h exp 1 00", last_ill, last_res);
      end
`endif
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      instr_valid = 1'b1; instr = 16'h1312;
      checks++;
      if (instr_ready !== 1'b1) begin
         errors++; $display("FAIL abort_ready_pre got=%b exp=1", instr_ready);
      end
      @(negedge clk);
      instr_valid = 1'b0; reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checks++;
      if (rf_wen !== 1'b0 || res_valid !== 1'b0) begin
         errors++; $display("FAIL abort_in_reset got wen=%b vld=%b exp 0 0", rf_wen, res_valid);
      end
      @(negedge clk);
      checks++;
      if (instr_ready !== 1'b1 || rf_wen !== 1'b0 || res_valid !== 1'b0) begin
         errors++;
         $display("FAIL abort_after got rdy=%b wen=%b vld=%b exp 1 0 0", instr_ready, rf_wen, res_valid);
      end
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b0 || rf_wen !== 1'b0 || rf_mem[3] !== 8'h08) begin
         errors++;
         $display("FAIL abort_late got vld=%b wen=%b r3=%h exp 0 0 08", res_valid, rf_wen, rf_mem[3]);
      end
      z_m = 0; c_m = 0;
   endtask

   task automatic test_random();
      for (int k = 0; k < 250; k++) stim.push_back(16'($urandom));
      run(30, 3000);
      for (int k = 0; k < 150; k++) stim.push_back({4'($urandom_range(0, 10)), 12'($urandom)});
      run(0, 2000);
      checks++;
      for (int i = 1; i < RFS; i++) begin
         if (rf_mem[i] !== 8'(arch[i])) begin
            errors++; $display("FAIL random_regs r%0d got=%h exp=%h", i, rf_mem[i], 8'(arch[i]));
            break;
         end
      end
   endtask

   initial begin
      test_reset();
      test_arith();
      test_back_to_back();
      test_r0_illegal();
      test_cmp();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/exec_ctrl.md
Name: exec_ctrl

Overview:
- Two-phase issue/execute controller wrapped around the general-purpose register file.
- Accepts one decoded instruction per handshake and drives the register file read addresses.
- Consumes the register file's registered operands one cycle later, computes the ALU result and drives the write-back port.
- Also reports the result and flags to downstream debug/status logic.

Parameters:
- DATA_WIDTH, 8: operand/result width.
- REG_FILE_SIZE, 16: number of GPRs.
- ADDR_WIDTH, $clog2(REG_FILE_SIZE): register index width.
- INSTR_WIDTH, 4+3*ADDR_WIDTH: instruction word width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- instr_valid  in  1  upstream instruction valid
- instr_ready  out  1  block can accept an instruction
- instr  in  INSTR_WIDTH  {opcode[3:0], rd, rs1, rs2}, MSB first
- rf_addr_a  out  ADDR_WIDTH  register file read address A
- rf_addr_b  out  ADDR_WIDTH  register file read address B
- rf_operand_a  in  DATA_WIDTH  registered read data A (1-cycle latency)
- rf_operand_b  in  DATA_WIDTH  registered read data B
- rf_wen  out  1  write enable
- rf_addr_write  out  ADDR_WIDTH  write index
- rf_data_in  out  DATA_WIDTH  write data
- res_valid  out  1  one-cycle pulse per retired instruction
- res_data  out  DATA_WIDTH  retired result
- flag_z  out  1  zero flag
- flag_c  out  1  carry/borrow flag
- illegal  out  1  one-cycle pulse on undefined opcode

Behaviour:
- Reset: clock clk, reset reset (synchronous, active-high).
  - State goes to IDLE; the instruction register is cleared.
  - instr_ready=1, rf_wen=0, res_valid=0, illegal=0.
  - res_data=0, flag_z=0, flag_c=0, rf_addr_*=0, rf_data_in=0.
- Reset mid-operation aborts the instruction: no write, no res_valid.
- FSM states: IDLE, READ, EXEC.
  - IDLE: instr_ready=1. If instr_valid, latch instr and go to READ.
  - READ: instr_ready=0. rf_addr_a=rs1 and rf_addr_b=rs2, driven from the latched instruction; the register file samples them at the end of this cycle. Go to EXEC.
  - EXEC: rf_operand_a/b are valid. The ALU is combinational on the operands. rf_wen, rf_addr_write=rd and rf_data_in=result are driven combinationally this cycle.
    - instr_ready=1 in EXEC. If instr_valid, latch the next instruction and go to READ; otherwise go to IDLE.
    - res_valid, res_data, the flags and illegal are registered at the end of EXEC and so appear the following cycle.
- Throughput: one instruction per 2 cycles back-to-back.
- Latency: acceptance edge to rf write edge is 2 cycles; res_valid is high in the cycle after the write.
- No RAW hazard: a write at the end of EXEC precedes the next READ sample edge.
- Opcodes (r = result):
  - 0 NOP: no write; res_valid pulses with res_data=0.
  - 1 ADD: r=a+b, c=carry-out.
  - 2 SUB: r=a-b, c=(a<b) unsigned borrow.
  - 3 AND, 4 OR, 5 XOR: c=0.
  - 6 SHL, 7 SHR: logical shift of a by b[$clog2(DATA_WIDTH)-1:0]; c=0.
  - 8 LDI: r={rs1,rs2} zero-extended or truncated to DATA_WIDTH; operands ignored.
  - 9 MOV: r=a.
  - Others are illegal: no write; illegal and res_valid pulse; res_data=0; flags unchanged.
- Flags:
  - Opcodes 1-7 update z=(r==0) and c.
  - NOP, LDI, MOV and illegal leave the flags unchanged.
- Write-back:
  - rf_wen is asserted for opcodes 1-9 even when rd=0; the register file discards writes to index 0.
  - res_data still reports the computed value when rd=0.
- All arithmetic wraps modulo 2^DATA_WIDTH.

Optional Feature:
- EXEC_CTRL_CMP_EN defined:
  - Opcode 0xA is CMP: computes a-b and updates z/c as SUB.
  - rf_wen=0 for CMP; res_valid pulses with res_data=a-b.
- Undefined: 0xA is illegal.

Decomposition:
- Package exec_ctrl_pkg holds:
  - opcode localparams OP_NOP..OP_MOV and OP_CMP;
  - FSM state encoding;
  - field-slice helper widths (OPC_W=4).
- One natural sub-module: exec_alu, purely combinational.
  - Inputs: opcode, a, b, imm.
  - Outputs: result, carry, writes_rd, updates_flags, illegal.

Test Plan:
- Reset then LDI r1,0x05; LDI r2,0x03; ADD r3,r1,r2 -> third write has rf_addr_write=3, rf_data_in=0x08; res_valid carries 0x08; z=0, c=0.
- LDI r1,0xFF; LDI r2,0x01; ADD r4,r1,r2 -> r4=0x00, z=1, c=1. Then SUB r5,r2,r1 -> 0x02, c=1 (borrow), z=0.
- Back-to-back LDI r6,0x0A followed immediately by MOV r7,r6 -> r7=0x0A with no stall. instr_valid held high gives instr_ready=1 every other cycle.
- LDI r0,0x55 then MOV r1,r0 -> rf_wen pulses for r0 but the MOV result is 0x00. Opcode 0xF -> illegal pulse, no rf_wen, flags unchanged.
- Assert reset during the READ of ADD r3,r1,r2 -> no rf_wen, no res_valid; instr_ready=1 the cycle after reset deasserts.
- With EXEC_CTRL_CMP_EN: CMP r1(0x03),r2(0x03) -> z=1, c=0, rf_wen=0. Without the macro the same word raises illegal.
